param_updown_counter: RTL and testbench

//  Parametrised up/down counter with programmable modulus, synchronous load/clear,

---
 rtl/param_updown_counter_pkg.sv | 14 +
 rtl/param_updown_counter_if.sv | 27 ++
 rtl/param_updown_counter_prescaler.sv | 27 ++
 rtl/param_updown_counter.sv | 62 ++++++
 tb/tb_param_updown_counter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/param_updown_counter_pkg.sv
// param_counter_pkg: direction/mode constants and the per-cycle action decode shared by the counter and its bench.
package param_counter_pkg;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_CLR,
        ACT_LOAD,
        ACT_STEP
    } act_e;
endpackage

// File: rtl/param_updown_counter_if.sv
// param_updown_counter_if: control and status bundle of the up/down counter.
interface param_updown_counter_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
);
    logic                  en;
    logic                  opcode;
    logic                  clr;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic [WIDTH-1:0]      max_val;
    logic [PRESCALE_W-1:0] prescale;
    logic                  ovf_clr;
    logic [WIDTH-1:0]      q_out;
    logic                  tc;
    logic                  ovf_sticky;

    modport master (
        output en, opcode, clr, load, load_val, max_val, prescale, ovf_clr,
        input  q_out, tc, ovf_sticky
    );

    modport slave (
        input  en, opcode, clr, load, load_val, max_val, prescale, ovf_clr,
        output q_out, tc, ovf_sticky
    );
endinterface

// File: rtl/param_updown_counter_prescaler.sv
// tick_prescaler: emits one tick every (prescale+1) enabled cycles; prescale is compared live.
module tick_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  clr_sync,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] p;
    logic                  hit;

    always_comb begin
        hit  = p == prescale;
        tick = en & hit & ~clr_sync;
    end

    // a phase above a lowered prescale simply runs on and wraps back round to it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            p <= '0;
        else
            p <= clr_sync ? '0 : !en ? p : hit ? '0 : p + 1'b1;
    end
endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: modulus up/down counter with prescaler, wrap/saturate boundary,
// terminal-count pulse and sticky overflow.
module param_updown_counter
    import param_counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SATURATE   = 0,
    parameter int PRESCALE_W = 4
) (
    input logic                   clk,
    input logic                   reset_n,
    param_updown_counter_if.slave bus
);
    act_e             act;
    logic             tick;
    logic             up;
    logic             at_bound;
    logic             boundary;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bound;
    logic [WIDTH-1:0] q_nxt;
    logic             tc;
    logic             ovf;

    tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (bus.en),
        .clr_sync (bus.clr | bus.load),
        .prescale (bus.prescale),
        .tick     (tick)
    );

    always_comb begin
        act      = bus.clr ? ACT_CLR : bus.load ? ACT_LOAD : tick ? ACT_STEP : ACT_HOLD;
        up       = bus.opcode == DIR_UP;
        at_bound = up ? (q >= bus.max_val) : (q == '0);
        boundary = (act == ACT_STEP) & at_bound;
        // saturate only moves a loaded out-of-range value back down onto the bound
        if (SATURATE == MODE_SAT)
            q_bound = (up && q > bus.max_val) ? bus.max_val : q;
        else
            q_bound = up ? '0 : bus.max_val;
        q_nxt = at_bound ? q_bound : up ? q + 1'b1 : q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            q   <= act == ACT_CLR ? '0 : act == ACT_LOAD ? bus.load_val : act == ACT_STEP ? q_nxt : q;
            tc  <= boundary;
            ovf <= boundary | (ovf & ~bus.ovf_clr);
        end
    end

    assign bus.q_out      = q;
    assign bus.tc         = tc;
    assign bus.ovf_sticky = ovf;
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: wrap and saturate counters driven in lockstep, checked against a cycle model.
module tb_param_updown_counter;
    import param_counter_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   mq[2];
    bit   mtc[2];
    bit   movf[2];
    int   mp;

    always #5 clk = ~clk;

    param_updown_counter_if #(.WIDTH(4), .PRESCALE_W(4)) if_w ();
    param_updown_counter_if #(.WIDTH(4), .PRESCALE_W(4)) if_s ();

    assign if_s.en       = if_w.en;
    assign if_s.opcode   = if_w.opcode;
    assign if_s.clr      = if_w.clr;
    assign if_s.load     = if_w.load;
    assign if_s.load_val = if_w.load_val;
    assign if_s.max_val  = if_w.max_val;
    assign if_s.prescale = if_w.prescale;
    assign if_s.ovf_clr  = if_w.ovf_clr;

    param_updown_counter #(.WIDTH(4), .SATURATE(MODE_WRAP), .PRESCALE_W(4)) dut_w (
        .clk(clk), .reset_n(reset_n), .bus(if_w));
    param_updown_counter #(.WIDTH(4), .SATURATE(MODE_SAT), .PRESCALE_W(4)) dut_s (
        .clk(clk), .reset_n(reset_n), .bus(if_s));

    wire [11:0] dut_vec = {if_w.q_out, if_w.tc, if_w.ovf_sticky, if_s.q_out, if_s.tc, if_s.ovf_sticky};

    function automatic logic [11:0] exp_vec();
        return {4'(mq[0]), mtc[0], movf[0], 4'(mq[1]), mtc[1], movf[1]};
    endfunction

    task automatic model_reset();
        mq = '{0, 0};
        mtc = '{0, 0};
        movf = '{0, 0};
        mp = 0;
    endtask

    // one rising edge of both counters, straight from the counting rules
    task automatic model_edge();
        int  mx;
        bit  up;
        bit  tick;
        bit  hit;
        mx = int'(if_w.max_val);
        up = if_w.opcode == DIR_UP;
        tick = 0;
        if (if_w.clr || if_w.load)
            mp = 0;
        else if (if_w.en) begin
            tick = mp == int'(if_w.prescale);
            mp = tick ? 0 : (mp + 1) % 16;
        end
        for (int m = 0; m < 2; m++) begin
            hit = tick && (up ? mq[m] >= mx : mq[m] == 0);
            if (if_w.clr)
                mq[m] = 0;
            else if (if_w.load)
                mq[m] = int'(if_w.load_val);
            else if (tick && !hit)
                mq[m] = up ? mq[m] + 1 : mq[m] - 1;
            else if (hit && m == MODE_WRAP)
                mq[m] = up ? 0 : mx;
            else if (hit && up && mq[m] > mx)
                mq[m] = mx;
            mtc[m] = hit;
            movf[m] = hit || (movf[m] && !if_w.ovf_clr);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_n) model_reset(); else model_edge();
        #1;
    endtask

    task automatic drive(input bit en, input bit op, input bit clr, input bit load,
                         input int lv, input int mx, input int ps, input bit oc);
        if_w.en = en;
        if_w.opcode = op;
        if_w.clr = clr;
        if_w.load = load;
        if_w.load_val = 4'(lv);
        if_w.max_val = 4'(mx);
        if_w.prescale = 4'(ps);
        if_w.ovf_clr = oc;
    endtask

    task automatic test_reset();
        drive(0, DIR_UP, 0, 0, 0, 9, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (dut_vec !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_init got %h want 000", dut_vec);
        end
        reset_n = 1'b1;
        drive(1, DIR_UP, 0, 1, 3, 9, 0, 0);
        step();
        if_w.load = 0;
        step();
        step();
        n_tests++;
        if (if_w.q_out !== 4'd5 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_precount got %h want %h (q=5)", dut_vec, exp_vec());
        end
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (dut_vec !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_async got %h want 000", dut_vec);
        end
        #1 reset_n = 1'b1;
        step();
        n_tests++;
        if (dut_vec !== exp_vec() || if_w.q_out !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_release got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_wrap_up();
        drive(1, DIR_UP, 0, 1, 8, 9, 0, 0);
        step();
        if_w.load = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) if_w.ovf_clr = 1;
            step();
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL wrap_up step %0d got %h want %h", i, dut_vec, exp_vec());
            end
            if (i == 1) begin
                n_tests++;
                if ({if_w.q_out, if_w.tc, if_w.ovf_sticky} !== 6'b0000_1_1) begin
                    n_fail++;
                    $display("FAIL wrap_up_boundary got q=%0d tc=%b ovf=%b want q=0 tc=1 ovf=1",
                             if_w.q_out, if_w.tc, if_w.ovf_sticky);
                end
            end
        end
        n_tests++;
        if (if_w.ovf_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_up_ovf_clr got %b want 0", if_w.ovf_sticky);
        end
        if_w.ovf_clr = 0;
    endtask

    task automatic test_wrap_down();
        drive(1, DIR_DOWN, 0, 1, 1, 9, 0, 0);
        step();
        if_w.load = 0;
        step();
        step();
        n_tests++;
        if (if_w.q_out !== 4'd9 || if_w.tc !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL wrap_down got %h want %h (q=9 tc=1)", dut_vec, exp_vec());
        end
        drive(1, DIR_DOWN, 0, 1, 0, 0, 0, 0);
        step();
        if_w.load = 0;
        for (int i = 0; i < 4; i++) begin
            if_w.opcode = 1'($urandom_range(1));
            step();
            n_tests++;
            if (if_w.q_out !== 4'd0 || if_w.tc !== 1'b1 || if_s.tc !== 1'b1 || dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL max_zero step %0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_saturate();
        drive(1, DIR_UP, 0, 1, 9, 9, 0, 0);
        step();
        if_w.load = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (if_s.q_out !== 4'd9 || if_s.tc !== 1'b1 || dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL sat_hold step %0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
        drive(1, DIR_UP, 0, 1, 12, 9, 0, 0);
        step();
        if_w.load = 0;
        step();
        n_tests++;
        if (if_s.q_out !== 4'd9 || if_s.tc !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL sat_clamp got %h want %h", dut_vec, exp_vec());
        end
        drive(1, DIR_DOWN, 0, 1, 0, 9, 0, 0);
        step();
        if_w.load = 0;
        step();
        n_tests++;
        if (if_s.q_out !== 4'd0 || if_s.tc !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL sat_floor got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_prescale();
        drive(1, DIR_UP, 0, 1, 0, 9, 2, 0);
        step();
        if_w.load = 0;
        for (int i = 0; i < 10; i++) begin
            if_w.en = !(i >= 4 && i < 8);
            step();
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL prescale step %0d got %h want %h", i, dut_vec, exp_vec());
            end
            if (i == 7 || i == 9) begin
                n_tests++;
                if (if_w.q_out !== 4'(i == 7 ? 1 : 2)) begin
                    n_fail++;
                    $display("FAIL prescale_phase step %0d got q=%0d want %0d", i, if_w.q_out, i == 7 ? 1 : 2);
                end
            end
        end
    endtask

    task automatic test_priority();
        drive(1, DIR_UP, 1, 1, 7, 9, 0, 0);
        step();
        n_tests++;
        if (if_w.q_out !== 4'd0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL clr_over_load got %h want %h", dut_vec, exp_vec());
        end
        drive(1, DIR_UP, 0, 1, 3, 9, 0, 0);
        step();
        n_tests++;
        if (if_w.q_out !== 4'd3 || if_w.tc !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL load_over_tick got %h want %h", dut_vec, exp_vec());
        end
        drive(1, DIR_UP, 0, 1, 9, 9, 0, 1);
        step();
        if_w.load = 0;
        step();
        n_tests++;
        if (if_w.ovf_sticky !== 1'b1 || if_w.tc !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL ovf_set_wins got %h want %h", dut_vec, exp_vec());
        end
        if_w.ovf_clr = 0;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            if_w.en = $urandom_range(9) != 0;
            if_w.opcode = 1'($urandom_range(1));
            if_w.clr = $urandom_range(30) == 0;
            if_w.load = $urandom_range(12) == 0;
            if_w.load_val = 4'($urandom_range(15));
            if_w.ovf_clr = $urandom_range(8) == 0;
            if ($urandom_range(20) == 0) if_w.max_val = 4'($urandom_range(15));
            if ($urandom_range(25) == 0) if_w.prescale = 4'($urandom_range(3));
            step();
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                if (errs++ < 10) $display("FAIL random cycle %0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_prescale();
        test_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
